config_uploader: RTL and testbench



---
 rtl/config_uploader_pkg.sv | 43 ++++
 rtl/config_uploader_header_byte_mux.sv | 42 ++++
 rtl/config_uploader.sv | 140 ++++++++++++++
 tb/tb_config_uploader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/config_uploader_pkg.sv
// Shared types and header layout for the ROM loader and the config uploader.
package config_uploader_pkg;

  // Header layout (byte offsets within the configuration header)
  localparam logic [7:0] HEADER_VERSION  = 8'h01;
  localparam int         SCREEN_SIZE_OFS = 3;
  localparam int         INPUT_MAP_OFS   = 8;
  localparam int         INPUT_B_OFS     = 40;
  localparam int         INPUT_BA_OFS    = 41;
  localparam int         INPUT_ACL_OFS   = 42;
  localparam int         HEADER_LEN      = 48;

  // Live system configuration, serialised into the header on upload
  typedef struct packed {
    logic [7:0]  mpu;
    logic [7:0]  screen_config;
    logic [11:0] screen_width;
    logic [11:0] screen_height;
    logic [31:0] input_s0_config;
    logic [31:0] input_s1_config;
    logic [31:0] input_s2_config;
    logic [31:0] input_s3_config;
    logic [31:0] input_s4_config;
    logic [31:0] input_s5_config;
    logic [31:0] input_s6_config;
    logic [31:0] input_s7_config;
    logic [7:0]  input_b_config;
    logic [7:0]  input_ba_config;
    logic [7:0]  input_acl_config;
  } system_config;

  // Uploader request sequencing
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    LO_REQ  = 3'd2,
    LO_WAIT = 3'd3,
    HI_REQ  = 3'd4,
    HI_WAIT = 3'd5,
    DONE    = 3'd6
  } upl_state_e;

endpackage

// File: rtl/config_uploader_header_byte_mux.sv
// Combinational header byte lookup: (sys_config, byte index) -> header byte.
// Bytes at index 43 and above are zero.
module header_byte_mux
  import config_uploader_pkg::*;
(
  input  system_config sys_config,
  input  logic [5:0]   byte_idx,
  output logic [7:0]   byte_val
);

  logic [HEADER_LEN-1:0][7:0] hdr_s;

  // Lay out the header image with multi-byte fields least-significant byte first
  always_comb begin
    hdr_s                          = '0;
    hdr_s[0]                       = HEADER_VERSION;
    hdr_s[1]                       = sys_config.mpu;
    hdr_s[2]                       = sys_config.screen_config;
    hdr_s[SCREEN_SIZE_OFS +: 3]    = {sys_config.screen_height, sys_config.screen_width};
    hdr_s[INPUT_MAP_OFS +: 4]      = sys_config.input_s0_config;
    hdr_s[INPUT_MAP_OFS + 4 +: 4]  = sys_config.input_s1_config;
    hdr_s[INPUT_MAP_OFS + 8 +: 4]  = sys_config.input_s2_config;
    hdr_s[INPUT_MAP_OFS + 12 +: 4] = sys_config.input_s3_config;
    hdr_s[INPUT_MAP_OFS + 16 +: 4] = sys_config.input_s4_config;
    hdr_s[INPUT_MAP_OFS + 20 +: 4] = sys_config.input_s5_config;
    hdr_s[INPUT_MAP_OFS + 24 +: 4] = sys_config.input_s6_config;
    hdr_s[INPUT_MAP_OFS + 28 +: 4] = sys_config.input_s7_config;
    hdr_s[INPUT_B_OFS]             = sys_config.input_b_config;
    hdr_s[INPUT_BA_OFS]            = sys_config.input_ba_config;
    hdr_s[INPUT_ACL_OFS]           = sys_config.input_acl_config;
  end

  // Select the requested byte; indices past the header image read as zero
  always_comb begin
    if (byte_idx < 6'(HEADER_LEN)) begin
      byte_val = hdr_s[byte_idx];
    end else begin
      byte_val = 8'h00;
    end
  end

endmodule

// File: rtl/config_uploader.sv
// Answers host word reads during an ioctl upload: header words are built from
// the live sys_config, higher words are fetched as two bytes from memory.
module config_uploader
  import config_uploader_pkg::*;
#(
  parameter logic [24:0] HEADER_WORDS = 25'h80,
  parameter int          MEM_LATENCY  = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ioctl_upload,
  input  logic         ioctl_rd,
  input  logic [24:0]  ioctl_addr,
  output logic [15:0]  ioctl_din,
  output logic         ioctl_din_valid,
  output logic         busy,
  input  system_config sys_config,
  output logic         rd_8bit,
  output logic [25:0]  addr_8bit,
  input  logic [7:0]   data_8bit
);

  // Last count of a wait phase: data_8bit is valid MEM_LATENCY cycles after the strobe
  localparam logic [2:0] WAIT_LAST = 3'(MEM_LATENCY - 1);

  upl_state_e  state_r;
  logic [24:0] lat_addr_r;   // header word address, or memory word offset
  logic [2:0]  wait_cnt_r;

  logic        region_s;
  logic [24:0] acc_base_s;
  logic [5:0]  lo_idx_s;
  logic [5:0]  hi_idx_s;
  logic        hdr_in_range_s;
  logic [7:0]  lo_byte_s;
  logic [7:0]  hi_byte_s;

  assign region_s       = (ioctl_addr >= HEADER_WORDS);
  assign acc_base_s     = ioctl_addr - HEADER_WORDS;
  assign lo_idx_s       = {lat_addr_r[4:0], 1'b0};
  assign hi_idx_s       = {lat_addr_r[4:0], 1'b1};
  // Words 32 and up map past byte 63 and are always zero
  assign hdr_in_range_s = (lat_addr_r[24:5] == 20'd0);

  header_byte_mux u_lo_mux (
    .sys_config (sys_config),
    .byte_idx   (lo_idx_s),
    .byte_val   (lo_byte_s)
  );

  header_byte_mux u_hi_mux (
    .sys_config (sys_config),
    .byte_idx   (hi_idx_s),
    .byte_val   (hi_byte_s)
  );

  // Request FSM with registered outputs; dropping ioctl_upload aborts silently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      lat_addr_r      <= 25'd0;
      wait_cnt_r      <= 3'd0;
      ioctl_din       <= 16'h0000;
      ioctl_din_valid <= 1'b0;
      busy            <= 1'b0;
      rd_8bit         <= 1'b0;
      addr_8bit       <= 26'd0;
    end else begin
      rd_8bit         <= 1'b0;
      ioctl_din_valid <= 1'b0;
      if ((state_r != IDLE) && !ioctl_upload) begin
        state_r <= IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (ioctl_rd && ioctl_upload) begin
              busy <= 1'b1;
              if (region_s) begin
                lat_addr_r <= acc_base_s;
                rd_8bit    <= 1'b1;
                addr_8bit  <= {acc_base_s, 1'b0};
                state_r    <= LO_REQ;
              end else begin
                lat_addr_r <= ioctl_addr;
                state_r    <= HDR;
              end
            end
          end
          HDR: begin
            if (hdr_in_range_s) begin
              ioctl_din <= {hi_byte_s, lo_byte_s};
            end else begin
              ioctl_din <= 16'h0000;
            end
            ioctl_din_valid <= 1'b1;
            busy            <= 1'b0;
            state_r         <= IDLE;
          end
          LO_REQ: begin
            wait_cnt_r <= 3'd0;
            state_r    <= LO_WAIT;
          end
          LO_WAIT: begin
            if (wait_cnt_r == WAIT_LAST) begin
              ioctl_din[7:0] <= data_8bit;
              rd_8bit        <= 1'b1;
              addr_8bit      <= {lat_addr_r, 1'b1};
              state_r        <= HI_REQ;
            end else begin
              wait_cnt_r <= wait_cnt_r + 3'd1;
            end
          end
          HI_REQ: begin
            wait_cnt_r <= 3'd0;
            state_r    <= HI_WAIT;
          end
          HI_WAIT: begin
            if (wait_cnt_r == WAIT_LAST) begin
              ioctl_din[15:8] <= data_8bit;
              state_r         <= DONE;
            end else begin
              wait_cnt_r <= wait_cnt_r + 3'd1;
            end
          end
          DONE: begin
            ioctl_din_valid <= 1'b1;
            busy            <= 1'b0;
            state_r         <= IDLE;
          end
          default: begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_config_uploader.sv
// Directed self-checking bench for config_uploader with a fixed-latency byte memory model.
module tb_config_uploader;
  import config_uploader_pkg::*;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         ioctl_upload;
  logic         ioctl_rd;
  logic [24:0]  ioctl_addr;
  logic [15:0]  ioctl_din;
  logic         ioctl_din_valid;
  logic         busy;
  system_config cfg;
  logic         rd_8bit;
  logic [25:0]  addr_8bit;
  logic [7:0]   data_8bit;

  int errors = 0;
  int checks = 0;

  logic [7:0]   mem [64];
  logic [LAT-1:0] pipe_v = '0;
  logic [7:0]   pipe_d [LAT];
  logic [25:0]  strobe_q [$];

  config_uploader #(.HEADER_WORDS(25'h80), .MEM_LATENCY(LAT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ioctl_upload    (ioctl_upload),
    .ioctl_rd        (ioctl_rd),
    .ioctl_addr      (ioctl_addr),
    .ioctl_din       (ioctl_din),
    .ioctl_din_valid (ioctl_din_valid),
    .busy            (busy),
    .sys_config      (cfg),
    .rd_8bit         (rd_8bit),
    .addr_8bit       (addr_8bit),
    .data_8bit       (data_8bit)
  );

  always #5 clk = ~clk;

  // Memory: data for a strobe appears LAT cycles later, garbage otherwise
  always @(posedge clk) begin
    pipe_v[0] <= rd_8bit;
    pipe_d[0] <= mem[addr_8bit[5:0]];
    for (int k = 1; k < LAT; k++) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_d[k] <= pipe_d[k-1];
    end
    if (rd_8bit) strobe_q.push_back(addr_8bit);
  end
  assign data_8bit = pipe_v[LAT-1] ? pipe_d[LAT-1] : 8'hEE;

  // Issue one read and watch max cycles: first-pulse latency, data, busy cycles, pulse count
  task automatic do_read(input logic [24:0] a, input int max, output int lat,
                         output logic [15:0] d, output int busy_cyc, output int pulses);
    @(negedge clk);
    strobe_q.delete();
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    lat = -1; d = 16'h0000; busy_cyc = 0; pulses = 0;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      ioctl_rd = 1'b0;
      if (busy) busy_cyc++;
      if (ioctl_din_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          d   = ioctl_din;
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (ioctl_din !== 16'h0000) begin errors++; $display("FAIL reset_din: got %h want 0000", ioctl_din); end
    checks++; if (ioctl_din_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ioctl_din_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rd_8bit !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", rd_8bit); end
    checks++; if (addr_8bit !== 26'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr_8bit); end
  endtask

  task automatic test_header();
    logic [24:0] words [14] = '{25'd0, 25'd1, 25'd2, 25'd3, 25'd4, 25'd5, 25'd6, 25'd18,
                                25'd19, 25'd20, 25'd21, 25'd22, 25'd32, 25'h7F};
    logic [15:0] exp [14]   = '{16'h2101, 16'hBC03, 16'h123A, 16'h0000, 16'hBEEF, 16'hDEAD,
                                16'hF00D, 16'h4567, 16'h0123, 16'h2211, 16'h0033, 16'h0000,
                                16'h0000, 16'h0000};
    int lat, bc, np;
    logic [15:0] d;
    for (int i = 0; i < 14; i++) begin
      do_read(words[i], 5, lat, d, bc, np);
      checks++; if (d !== exp[i]) begin errors++; $display("FAIL hdr_word_%0d: got %h want %h", words[i], d, exp[i]); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL hdr_lat_%0d: got %0d want 2", words[i], lat); end
      checks++; if (np !== 1 || bc !== 1) begin errors++; $display("FAIL hdr_pulse_%0d: pulses %0d busy %0d want 1 1", words[i], np, bc); end
    end
    checks++; if (strobe_q.size() !== 0) begin errors++; $display("FAIL hdr_no_strobe: got %0d strobes want 0", strobe_q.size()); end
  endtask

  task automatic test_memory();
    logic [24:0] addrs [3] = '{25'h80, 25'h83, 25'h1FFFFFF};
    logic [15:0] exp [3]   = '{16'h5AA5, 16'h3CC3, 16'h8877};
    logic [25:0] s0 [3]    = '{26'h0, 26'h6, 26'h3FFFEFE};
    logic [25:0] s1 [3]    = '{26'h1, 26'h7, 26'h3FFFEFF};
    int lat, bc, np;
    logic [15:0] d;
    logic [25:0] g0, g1;
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], 12, lat, d, bc, np);
      g0 = (strobe_q.size() > 0) ? strobe_q[0] : 26'h3FFFFFF;
      g1 = (strobe_q.size() > 1) ? strobe_q[1] : 26'h3FFFFFF;
      checks++; if (d !== exp[i]) begin errors++; $display("FAIL mem_data_%h: got %h want %h", addrs[i], d, exp[i]); end
      checks++; if (lat !== 8) begin errors++; $display("FAIL mem_lat_%h: got %0d want 8", addrs[i], lat); end
      checks++; if (bc !== 7) begin errors++; $display("FAIL mem_busy_%h: got %0d want 7", addrs[i], bc); end
      checks++; if (np !== 1) begin errors++; $display("FAIL mem_pulses_%h: got %0d want 1", addrs[i], np); end
      checks++; if (strobe_q.size() !== 2 || g0 !== s0[i] || g1 !== s1[i]) begin
        errors++; $display("FAIL mem_strobes_%h: got n=%0d %h %h want 2 %h %h", addrs[i], strobe_q.size(), g0, g1, s0[i], s1[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat = -1, np = 0, bseen = 0;
    logic [15:0] d = 16'h0000;
    @(negedge clk);
    ioctl_addr = 25'h81; ioctl_rd = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ioctl_rd = 1'b0;
      if (ioctl_din_valid) begin
        np++;
        if (lat < 0) begin lat = k; d = ioctl_din; end
      end
      if (k == 3) begin ioctl_addr = 25'h0; ioctl_rd = 1'b1; end
    end
    checks++; if (np !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d want 1", np); end
    checks++; if (d !== 16'h9911) begin errors++; $display("FAIL b2b_data: got %h want 9911", d); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_lat: got %0d want 8", lat); end
    // Reads with the upload session closed are ignored
    ioctl_upload = 1'b0;
    np = 0;
    @(negedge clk);
    ioctl_addr = 25'h0; ioctl_rd = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ioctl_rd = 1'b0;
      if (ioctl_din_valid) np++;
      if (busy) bseen++;
    end
    ioctl_upload = 1'b1;
    checks++; if (np !== 0 || bseen !== 0) begin errors++; $display("FAIL no_upload_ignored: pulses %0d busy %0d want 0 0", np, bseen); end
  endtask

  task automatic test_upload_drop();
    int np = 0, lat, bc;
    logic b6 = 1'b1;
    logic [15:0] d;
    @(negedge clk);
    ioctl_addr = 25'h80; ioctl_rd = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ioctl_rd = 1'b0;
      if (ioctl_din_valid) np++;
      if (k == 6) b6 = busy;
      if (k == 5) ioctl_upload = 1'b0;
    end
    checks++; if (b6 !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", b6); end
    checks++; if (np !== 0) begin errors++; $display("FAIL drop_no_pulse: got %0d want 0", np); end
    ioctl_upload = 1'b1;
    do_read(25'h80, 12, lat, d, bc, np);
    checks++; if (d !== 16'h5AA5 || lat !== 8) begin errors++; $display("FAIL drop_recover: got %h lat %0d want 5aa5 lat 8", d, lat); end
  endtask

  task automatic test_async_reset();
    int np = 0, lat, bc;
    logic [15:0] d;
    @(negedge clk);
    ioctl_addr = 25'h83; ioctl_rd = 1'b1;
    @(negedge clk); ioctl_rd = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ioctl_din !== 16'h0000) begin errors++; $display("FAIL areset_din: got %h want 0000", ioctl_din); end
    checks++; if (busy !== 1'b0 || ioctl_din_valid !== 1'b0) begin errors++; $display("FAIL areset_busy_valid: got %b %b want 0 0", busy, ioctl_din_valid); end
    checks++; if (rd_8bit !== 1'b0 || addr_8bit !== 26'd0) begin errors++; $display("FAIL areset_mem: got %b %h want 0 0", rd_8bit, addr_8bit); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ioctl_din_valid) np++;
    end
    checks++; if (np !== 0) begin errors++; $display("FAIL areset_no_pulse: got %0d want 0", np); end
    do_read(25'd1, 5, lat, d, bc, np);
    checks++; if (d !== 16'hBC03 || lat !== 2) begin errors++; $display("FAIL areset_hdr: got %h lat %0d want bc03 lat 2", d, lat); end
  endtask

  initial begin
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = 25'd0;
    cfg          = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 1);
    mem[0]  = 8'hA5; mem[1]  = 8'h5A;
    mem[2]  = 8'h11; mem[3]  = 8'h99;
    mem[6]  = 8'hC3; mem[7]  = 8'h3C;
    mem[62] = 8'h77; mem[63] = 8'h88;
    cfg.mpu              = 8'h21;
    cfg.screen_config    = 8'h03;
    cfg.screen_width     = 12'hABC;
    cfg.screen_height    = 12'h123;
    cfg.input_s0_config  = 32'hDEADBEEF;
    cfg.input_s1_config  = 32'hCAFEF00D;
    cfg.input_s7_config  = 32'h01234567;
    cfg.input_b_config   = 8'h11;
    cfg.input_ba_config  = 8'h22;
    cfg.input_acl_config = 8'h33;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    ioctl_upload = 1'b1;
    test_header();
    test_memory();
    test_back_to_back();
    test_upload_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
